// File: rtl/lsu_dccm_arb_pkg.sv
// Shared types for the DCCM port arbiter: FSM state encoding and starvation-counter sizing.
package lsu_dccm_arb_pkg;

  typedef enum logic [1:0] {
    ArbIdle     = 2'd0,
    ArbSbForce  = 2'd1,
    ArbDmaForce = 2'd2
  } lsu_arb_state_t;

  localparam int unsigned StarveCntW = 4;
  localparam logic [StarveCntW-1:0] StarveCntMax = '1;

endpackage

// File: rtl/lsu_dccm_arb_if.sv
// Request/grant bundle between the DCCM requesters (master) and the arbiter (slave).
interface lsu_dccm_arb_if #(
  parameter int unsigned BankBits = 3
);
  logic                freeze;
  logic                ld_rden_dc1;
  logic [BankBits-1:0] ld_lo_bank;
  logic [BankBits-1:0] ld_hi_bank;
  logic                sb_req;
  logic                sb_pic;
  logic [BankBits-1:0] sb_bank;
  logic                dma_req;
  logic [BankBits-1:0] dma_bank;
  logic                sb_gnt;
  logic                dma_gnt;
  logic                ld_block;
  logic [1:0]          arb_state;

  modport master (
    output freeze, ld_rden_dc1, ld_lo_bank, ld_hi_bank,
    output sb_req, sb_pic, sb_bank, dma_req, dma_bank,
    input  sb_gnt, dma_gnt, ld_block, arb_state
  );

  modport slave (
    input  freeze, ld_rden_dc1, ld_lo_bank, ld_hi_bank,
    input  sb_req, sb_pic, sb_bank, dma_req, dma_bank,
    output sb_gnt, dma_gnt, ld_block, arb_state
  );
endinterface

// File: rtl/lsu_starve_ctr.sv
// Saturating count of cycles a requester lost the DCCM port; flags when the next count
// reaches the force threshold.
module lsu_starve_ctr
  import lsu_dccm_arb_pkg::*;
#(
  parameter int unsigned Threshold = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  gnt_i,
  input  logic                  freeze_i,
  output logic [StarveCntW-1:0] cnt_o,
  output logic                  hit_o
);

  localparam logic [StarveCntW-1:0] Thr = StarveCntW'(Threshold);

  logic [StarveCntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (gnt_i) begin
      cnt_d = '0;
    end else if (req_i && !freeze_i && (cnt_q != StarveCntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A stale count left by a flushed requester must not force the port.
  assign hit_o = req_i && (cnt_d >= Thr);
  assign cnt_o = cnt_q;

endmodule

// File: rtl/lsu_dccm_arb.sv
// DCCM port arbiter: loads win by default; starved stbuf/DMA force the port by blocking
// one load issue slot via the registered ld_block.
module lsu_dccm_arb
  import lsu_dccm_arb_pkg::*;
#(
  parameter int unsigned BankLsb   = 2,
  parameter int unsigned BankBits  = 3,
  parameter int unsigned SbStarve  = 7,
  parameter int unsigned DmaStarve = 3
) (
  input  logic          clk,
  input  logic          rst_l,
  lsu_dccm_arb_if.slave arb
);

  if (BankLsb + BankBits > 32) begin : gen_param_err
    $error("bank index field exceeds the 32-bit address");
  end

  lsu_arb_state_t state_d, state_q;
  logic           ld_block_q;
  logic           cf_sb, cf_dma;
  logic           sb_gnt_idle, dma_gnt_idle;
  logic           sb_gnt, dma_gnt;
  logic           sb_hit, dma_hit;
  logic [StarveCntW-1:0] sb_cnt, dma_cnt;

  assign cf_sb  = arb.ld_rden_dc1 &&
                  ((arb.sb_bank == arb.ld_lo_bank) || (arb.sb_bank == arb.ld_hi_bank));
  assign cf_dma = arb.ld_rden_dc1 &&
                  ((arb.dma_bank == arb.ld_lo_bank) || (arb.dma_bank == arb.ld_hi_bank));

  assign sb_gnt_idle  = arb.sb_req && !arb.freeze && (arb.sb_pic || !cf_sb);
  // DMA occupies both banks, so any banked stbuf write or live load shuts it out.
  assign dma_gnt_idle = arb.dma_req && !arb.freeze && !arb.ld_rden_dc1 && !cf_dma &&
                        !(sb_gnt_idle && !arb.sb_pic);

  always_comb begin
    sb_gnt  = sb_gnt_idle;
    dma_gnt = dma_gnt_idle;
    unique case (state_q)
      ArbDmaForce: begin
        sb_gnt  = arb.sb_req && !arb.freeze && arb.sb_pic;
        dma_gnt = arb.dma_req && !arb.freeze && !arb.ld_rden_dc1;
      end
      default: begin
        sb_gnt  = sb_gnt_idle;
        dma_gnt = dma_gnt_idle;
      end
    endcase
  end

  lsu_starve_ctr #(
    .Threshold(SbStarve)
  ) u_sb_ctr (
    .clk_i   (clk),
    .rst_ni  (rst_l),
    .req_i   (arb.sb_req),
    .gnt_i   (sb_gnt),
    .freeze_i(arb.freeze),
    .cnt_o   (sb_cnt),
    .hit_o   (sb_hit)
  );

  lsu_starve_ctr #(
    .Threshold(DmaStarve)
  ) u_dma_ctr (
    .clk_i   (clk),
    .rst_ni  (rst_l),
    .req_i   (arb.dma_req),
    .gnt_i   (dma_gnt),
    .freeze_i(arb.freeze),
    .cnt_o   (dma_cnt),
    .hit_o   (dma_hit)
  );

  always_comb begin
    state_d = state_q;
    if (!arb.freeze) begin
      unique case (state_q)
        ArbIdle: begin
          if (sb_hit) begin
            state_d = ArbSbForce;
          end else if (dma_hit) begin
            state_d = ArbDmaForce;
          end
        end
        ArbSbForce: begin
          if (sb_gnt || !arb.sb_req) begin
            state_d = dma_hit ? ArbDmaForce : ArbIdle;
          end
        end
        ArbDmaForce: begin
          if (dma_gnt || !arb.dma_req) begin
            state_d = sb_hit ? ArbSbForce : ArbIdle;
          end
        end
        default: state_d = ArbIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= ArbIdle;
      ld_block_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_block_q <= (state_d != ArbIdle);
    end
  end

  assign arb.sb_gnt    = sb_gnt;
  assign arb.dma_gnt   = dma_gnt;
  assign arb.ld_block  = ld_block_q;
  assign arb.arb_state = state_q;

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Directed bench for lsu_dccm_arb: grant rules, starvation forcing, freeze and async reset.
module tb_lsu_dccm_arb;

  logic clk;
  logic rst_l;
  int   checks;
  int   failures;

  lsu_dccm_arb_if #(.BankBits(3)) bus ();

  lsu_dccm_arb #(
    .BankLsb  (2),
    .BankBits (3),
    .SbStarve (7),
    .DmaStarve(3)
  ) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .arb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // DMA must keep its request up until it is granted.
  assert property (@(posedge clk) disable iff (!rst_l)
                   (bus.dma_req && !bus.dma_gnt) |=> bus.dma_req)
    else begin
      failures++;
      $error("FAIL dma_req_hold: observed=dropped expected=held");
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_l           = 1'b0;
    bus.freeze      = 1'b0;
    bus.ld_rden_dc1 = 1'b0;
    bus.ld_lo_bank  = 3'd0;
    bus.ld_hi_bank  = 3'd0;
    bus.sb_req      = 1'b0;
    bus.sb_pic      = 1'b0;
    bus.sb_bank     = 3'd0;
    bus.dma_req     = 1'b0;
    bus.dma_bank    = 3'd0;
    repeat (2) cyc();

    // 1: grant is combinational even while reset is held
    bus.sb_req = 1'b1;
    #1;
    chk("t1_rst_sb_gnt", 32'(bus.sb_gnt), 32'd1);
    chk("t1_rst_state", 32'(bus.arb_state), 32'd0);
    chk("t1_rst_ld_block", 32'(bus.ld_block), 32'd0);
    chk("t1_rst_sb_cnt", 32'(dut.u_sb_ctr.cnt_o), 32'd0);
    chk("t1_rst_dma_cnt", 32'(dut.u_dma_ctr.cnt_o), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    cyc();
    chk("t1_sb_gnt", 32'(bus.sb_gnt), 32'd1);
    chk("t1_sb_cnt", 32'(dut.u_sb_ctr.cnt_o), 32'd0);
    bus.sb_req = 1'b0;
    #1;
    chk("t1_no_req_no_gnt", 32'(bus.sb_gnt), 32'd0);

    // 3: non-conflicting bank, conflict on the hi bank, PIC never conflicts
    cyc();
    bus.ld_rden_dc1 = 1'b1;
    bus.ld_lo_bank  = 3'd3;
    bus.ld_hi_bank  = 3'd4;
    bus.sb_req      = 1'b1;
    bus.sb_bank     = 3'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_sb_gnt_free_bank", 32'(bus.sb_gnt), 32'd1);
      cyc();
      chk("t3_sb_cnt", 32'(dut.u_sb_ctr.cnt_o), 32'd0);
    end
    bus.sb_bank = 3'd4;
    #1;
    chk("t3_hi_bank_conflict", 32'(bus.sb_gnt), 32'd0);
    bus.sb_pic = 1'b1;
    #1;
    chk("t3_pic_ignores_bank", 32'(bus.sb_gnt), 32'd1);
    cyc();
    // idle, no load: PIC stbuf and DMA both win
    bus.ld_rden_dc1 = 1'b0;
    bus.dma_req     = 1'b1;
    bus.dma_bank    = 3'd2;
    #1;
    chk("t3_pic_sb_gnt", 32'(bus.sb_gnt), 32'd1);
    chk("t3_pic_dma_gnt", 32'(bus.dma_gnt), 32'd1);
    cyc();
    // banked stbuf beats DMA in idle
    bus.sb_pic  = 1'b0;
    bus.sb_bank = 3'd6;
    #1;
    chk("t3_sb_beats_dma_sb", 32'(bus.sb_gnt), 32'd1);
    chk("t3_sb_beats_dma_dma", 32'(bus.dma_gnt), 32'd0);
    cyc();
    chk("t3_dma_cnt_one", 32'(dut.u_dma_ctr.cnt_o), 32'd1);
    bus.sb_req = 1'b0;
    #1;
    chk("t3_dma_gnt_after_sb", 32'(bus.dma_gnt), 32'd1);
    cyc();
    chk("t3_dma_cnt_clr", 32'(dut.u_dma_ctr.cnt_o), 32'd0);
    bus.dma_req = 1'b0;

    // 2: stbuf starved by loads on bank 3 for 7 cycles
    bus.ld_rden_dc1 = 1'b1;
    bus.ld_lo_bank  = 3'd3;
    bus.ld_hi_bank  = 3'd3;
    bus.sb_req      = 1'b1;
    bus.sb_bank     = 3'd3;
    #1;
    chk("t2_sb_lost", 32'(bus.sb_gnt), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("t2_sb_cnt_ramp", 32'(dut.u_sb_ctr.cnt_o), 32'(k));
      chk("t2_still_idle", 32'(bus.arb_state), 32'd0);
    end
    cyc();
    chk("t2_sb_cnt_7", 32'(dut.u_sb_ctr.cnt_o), 32'd7);
    chk("t2_state_sb_force", 32'(bus.arb_state), 32'd1);
    chk("t2_ld_block", 32'(bus.ld_block), 32'd1);
    chk("t2_inflight_load_blocks", 32'(bus.sb_gnt), 32'd0);
    bus.ld_rden_dc1 = 1'b0;
    #1;
    chk("t2_forced_sb_gnt", 32'(bus.sb_gnt), 32'd1);
    cyc();
    chk("t2_back_idle", 32'(bus.arb_state), 32'd0);
    chk("t2_ld_block_drop", 32'(bus.ld_block), 32'd0);
    chk("t2_sb_cnt_clr", 32'(dut.u_sb_ctr.cnt_o), 32'd0);
    bus.sb_req = 1'b0;

    // 4: DMA starved by loads, stbuf banked write held off in DMA_FORCE
    bus.ld_rden_dc1 = 1'b1;
    bus.ld_lo_bank  = 3'd2;
    bus.ld_hi_bank  = 3'd2;
    bus.dma_req     = 1'b1;
    bus.dma_bank    = 3'd2;
    #1;
    chk("t4_dma_lost", 32'(bus.dma_gnt), 32'd0);
    repeat (2) cyc();
    chk("t4_still_idle", 32'(bus.arb_state), 32'd0);
    cyc();
    chk("t4_dma_cnt_3", 32'(dut.u_dma_ctr.cnt_o), 32'd3);
    chk("t4_state_dma_force", 32'(bus.arb_state), 32'd2);
    chk("t4_ld_block", 32'(bus.ld_block), 32'd1);
    bus.ld_rden_dc1 = 1'b0;
    bus.sb_req      = 1'b1;
    bus.sb_bank     = 3'd1;
    #1;
    chk("t4_dma_gnt", 32'(bus.dma_gnt), 32'd1);
    chk("t4_sb_held_off", 32'(bus.sb_gnt), 32'd0);
    cyc();
    chk("t4_back_idle", 32'(bus.arb_state), 32'd0);
    chk("t4_dma_cnt_clr", 32'(dut.u_dma_ctr.cnt_o), 32'd0);
    chk("t4_sb_cnt_one", 32'(dut.u_sb_ctr.cnt_o), 32'd1);
    bus.dma_req = 1'b0;
    #1;
    chk("t4_sb_gnt_idle", 32'(bus.sb_gnt), 32'd1);
    cyc();
    bus.sb_req = 1'b0;

    // 5: both thresholds hit together
    bus.ld_rden_dc1 = 1'b1;
    bus.ld_lo_bank  = 3'd3;
    bus.ld_hi_bank  = 3'd3;
    bus.sb_req      = 1'b1;
    bus.sb_bank     = 3'd3;
    repeat (4) cyc();
    bus.dma_req  = 1'b1;
    bus.dma_bank = 3'd0;
    repeat (3) cyc();
    chk("t5_sb_cnt", 32'(dut.u_sb_ctr.cnt_o), 32'd7);
    chk("t5_dma_cnt", 32'(dut.u_dma_ctr.cnt_o), 32'd3);
    chk("t5_sb_force_first", 32'(bus.arb_state), 32'd1);
    bus.ld_rden_dc1 = 1'b0;
    #1;
    chk("t5_sb_gnt", 32'(bus.sb_gnt), 32'd1);
    chk("t5_dma_waits", 32'(bus.dma_gnt), 32'd0);
    cyc();
    chk("t5_dma_force_next", 32'(bus.arb_state), 32'd2);
    chk("t5_ld_block_kept", 32'(bus.ld_block), 32'd1);
    bus.sb_req = 1'b0;
    #1;
    chk("t5_dma_gnt", 32'(bus.dma_gnt), 32'd1);
    cyc();
    chk("t5_idle", 32'(bus.arb_state), 32'd0);
    chk("t5_ld_block_drop", 32'(bus.ld_block), 32'd0);
    bus.dma_req = 1'b0;

    // 6: freeze holds SB_FORCE, then async reset
    bus.ld_rden_dc1 = 1'b1;
    bus.ld_lo_bank  = 3'd6;
    bus.ld_hi_bank  = 3'd6;
    bus.sb_req      = 1'b1;
    bus.sb_bank     = 3'd6;
    repeat (7) cyc();
    chk("t6_sb_force", 32'(bus.arb_state), 32'd1);
    bus.freeze      = 1'b1;
    bus.ld_rden_dc1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_frz_no_gnt", 32'(bus.sb_gnt), 32'd0);
      cyc();
      chk("t6_frz_state", 32'(bus.arb_state), 32'd1);
      chk("t6_frz_cnt", 32'(dut.u_sb_ctr.cnt_o), 32'd7);
      chk("t6_frz_ld_block", 32'(bus.ld_block), 32'd1);
    end
    #1;
    rst_l = 1'b0;
    #1;
    chk("t6_async_state", 32'(bus.arb_state), 32'd0);
    chk("t6_async_ld_block", 32'(bus.ld_block), 32'd0);
    chk("t6_async_sb_cnt", 32'(dut.u_sb_ctr.cnt_o), 32'd0);
    chk("t6_async_no_gnt", 32'(bus.sb_gnt), 32'd0);
    bus.freeze = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    cyc();
    chk("t6_post_rst_idle", 32'(bus.arb_state), 32'd0);
    chk("t6_post_rst_sb_gnt", 32'(bus.sb_gnt), 32'd1);
    bus.sb_req = 1'b0;
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
